// File: rtl/demux_20_4_16x20_if.sv
// Bus interface for demux_20_4_16x20: one shared producer side (in/addr/valid)
// and sixteen registered 20-bit consumer channels plus a one-hot strobe.
// master: the producer/consumer environment around the demux.
// slave : the demux itself.
interface demux_20_4_16x20_if;
    logic [19:0]       in;
    logic [3:0]        addr;
    logic              valid;
    logic [15:0][19:0] out;
    logic [15:0]       out_sel;

    modport master (
        output in,
        output addr,
        output valid,
        input  out,
        input  out_sel
    );

    modport slave (
        input  in,
        input  addr,
        input  valid,
        output out,
        output out_sel
    );
endinterface

// File: rtl/demux_20_4_16x20.sv
// Registered 1-to-16 demultiplexor for 20-bit words.
// The word on bus.in is loaded into channel bus.addr when bus.valid is high,
// and bus.out_sel carries the matching one-hot strobe, one clock later.
// Build option: define DEMUX_HOLD_EN to make each channel an independent
// hold register; by default every non-addressed channel clears to zero
// each cycle, so at most one channel is ever non-zero.
module demux_20_4_16x20 (
    input  logic                       clk,
    input  logic                       rst_n,
    demux_20_4_16x20_if.slave          bus
);

    // Map a 4-bit channel index to its one-hot strobe.
    function automatic logic [15:0] onehot_decode(input logic [3:0] idx);
        onehot_decode = 16'h0001 << idx;
    endfunction

    logic [15:0][19:0] out_q;
    logic [15:0][19:0] out_d;
    logic [15:0]       out_sel_q;
    logic [15:0]       out_sel_d;

    // Next-state routing: pick the idle value per build, then overlay the addressed channel.
    always_comb begin
`ifdef DEMUX_HOLD_EN
        out_d = out_q;
`else
        out_d = {16{20'h00000}};
`endif
        out_sel_d = 16'h0000;
        if (bus.valid) begin
            out_d[bus.addr] = bus.in;
            out_sel_d       = onehot_decode(bus.addr);
        end else begin
            out_sel_d = 16'h0000;
        end
    end

    // Output registers; reset has priority and discards the word sampled on that edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= {16{20'h00000}};
            out_sel_q <= 16'h0000;
        end else begin
            out_q     <= out_d;
            out_sel_q <= out_sel_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.out_sel = out_sel_q;

endmodule

// File: tb/tb_demux_20_4_16x20.sv
// Directed testbench for demux_20_4_16x20 (checks follow the active build option).
module tb_demux_20_4_16x20;

    logic clk;
    logic rst_n;

    demux_20_4_16x20_if bus_if ();

    demux_20_4_16x20 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0][19:0] e_out;
    logic [15:0]       e_sel;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_out%0d", tag, k), bus_if.out[k], e_out[k]);
        end
        chk($sformatf("%s_sel", tag), {4'h0, bus_if.out_sel}, {4'h0, e_sel});
    endtask

    // Drive one cycle of inputs, step one edge, update the expected state, check.
    task automatic step(input string tag, input logic r, input logic [3:0] a,
                        input logic [19:0] d, input logic v);
        rst_n        = r;
        bus_if.addr  = a;
        bus_if.in    = d;
        bus_if.valid = v;
        @(posedge clk);
        #1;
        if (!r) begin
            e_out = {16{20'h00000}};
            e_sel = 16'h0000;
        end else begin
`ifndef DEMUX_HOLD_EN
            e_out = {16{20'h00000}};
`endif
            e_sel = 16'h0000;
            if (v) begin
                e_out[a] = d;
                e_sel    = 16'h0001 << a;
            end
        end
        chk_all(tag);
    endtask

    initial begin
        logic [3:0]  ra;
        logic [19:0] rd;
        int unsigned seed_dummy;

        e_out        = {16{20'h00000}};
        e_sel        = 16'h0000;
        rst_n        = 1'b0;
        bus_if.in    = 20'hFFFFF;
        bus_if.addr  = 4'd5;
        bus_if.valid = 1'b1;
        #2;

        // Reset held two cycles with a valid word present.
        step("rst1", 1'b0, 4'd5, 20'hFFFFF, 1'b1);
        step("rst2", 1'b0, 4'd5, 20'hFFFFF, 1'b1);

        // Address sweep.
        for (int a = 0; a < 16; a++) begin
            step($sformatf("sweep%0d", a), 1'b1, 4'(a), 20'hA5A5A, 1'b1);
        end

        // Valid gating on channel 3.
        step("vgate_off", 1'b1, 4'd3, 20'h12345, 1'b0);
`ifndef DEMUX_HOLD_EN
        chk("vgate_off_out3_const", bus_if.out[3], 20'h00000);
`endif
        step("vgate_on", 1'b1, 4'd3, 20'h12345, 1'b1);
        chk("vgate_on_out3_const", bus_if.out[3], 20'h12345);
        chk("vgate_on_sel_const", {4'h0, bus_if.out_sel}, 20'h00008);

        // Hold scenario: ch2 then ch9, then idle.
        step("hold_w2", 1'b1, 4'd2, 20'h00001, 1'b1);
        step("hold_w9", 1'b1, 4'd9, 20'h00002, 1'b1);
        step("hold_idle", 1'b1, 4'd9, 20'h00003, 1'b0);
`ifdef DEMUX_HOLD_EN
        chk("hold_out2_const", bus_if.out[2], 20'h00001);
        chk("hold_out9_const", bus_if.out[9], 20'h00002);
`else
        chk("idle_out9_const", bus_if.out[9], 20'h00000);
`endif
        step("hold_rst", 1'b0, 4'd9, 20'h00004, 1'b1);
        chk("hold_rst_out2_const", bus_if.out[2], 20'h00000);
        step("hold_rel_idle", 1'b1, 4'd0, 20'h00000, 1'b0);

        // Random routing, seeded.
        seed_dummy = $urandom(74651);
        for (int i = 0; i < 12; i++) begin
            ra = 4'($urandom_range(15, 0));
            rd = 20'($urandom_range(20'hFFFFF, 0));
            step($sformatf("rand%0d", i), 1'b1, ra, rd, 1'b1);
        end

        // Mid-stream reset while streaming to ch15.
        step("ms_a", 1'b1, 4'd15, 20'h0F0F0, 1'b1);
        chk("ms_a_out15_const", bus_if.out[15], 20'h0F0F0);
        step("ms_b", 1'b1, 4'd15, 20'h0F0F1, 1'b1);
        step("ms_rst", 1'b0, 4'd15, 20'h0F0F2, 1'b1);
        chk("ms_rst_out15_const", bus_if.out[15], 20'h00000);
        chk("ms_rst_sel_const", {4'h0, bus_if.out_sel}, 20'h00000);
        step("ms_resume", 1'b1, 4'd7, 20'h0BEEF, 1'b1);
        chk("ms_resume_out7_const", bus_if.out[7], 20'h0BEEF);
        chk("ms_resume_sel_const", {4'h0, bus_if.out_sel}, 20'h00080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
